vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates 640x480@60 VGA raster timing (800x525 total) and drives the pixel coordinate bus (x, y) consumed by the pixel-generating game and graphics blocks.
- Produces hsync, vsync, active-video and per-line/per-frame strobes from a shared pixel-rate enable.
- Sits between the clock-enable divider and the pixel generators and VGA output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync driven low during sync pulse

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel-rate enable; counters advance only on clk edges where pix_en=1
x  output  10  horizontal pixel coordinate, valid while active=1
y  output  9  vertical pixel coordinate, valid while active=1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
active  output  1  1 while (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE)
line_start  output  1  one-clk pulse when a new line begins
frame_start  output  1  one-clk pulse when a new frame begins

Behaviour:
- Internal counters: h_cnt, v_cnt, both 10 bits. H_TOTAL = 800 = sum of the four H parameters; V_TOTAL = 525 = sum of the four V parameters.
- Async reset (rst_n=0, in any state):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - x=0, y=0, active=0, line_start=0, frame_start=0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
- Counter advance, on a clk edge with pix_en=1:
  - If h_cnt = H_TOTAL-1: h_cnt wraps to 0 and v_cnt increments. If v_cnt = V_TOTAL-1 it wraps to 0.
  - Otherwise h_cnt increments and v_cnt holds.
  - With reset to the last position, the first pix_en after reset lands on (0,0), so pixel 0 of the first frame is not skipped.
- Registered outputs:
  - All outputs are flops, updated on the same edge as the counters and decoded from the next counter values. They reflect the counter position with zero lag and are glitch-free.
  - With pix_en=0, counters and all outputs hold, except the strobes, which clear to 0.
- Coordinates:
  - x = h_cnt and y = v_cnt[8:0] when the new position is active.
  - Otherwise x=0 and y=0.
- Sync decode, on the new position:
  - hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. vsync transitions align with h_cnt=0.
- Strobes:
  - line_start = 1 for exactly one clk, on the edge where the counters move to h_cnt=0, and 0 on the next clk regardless of pix_en.
  - frame_start = 1 for exactly one clk, on the edge where the counters move to (0,0). It coincides with that line_start.
- Widths: compares are unsigned 10-bit. Parameters are elaboration constants; no runtime reconfiguration.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). The next pix_en after release starts a fresh frame at (0,0) with frame_start.

Test Plan:
- Reset then hold rst_n=0 -> x=0, y=0, active=0, hsync=1, vsync=1, both strobes 0. Release, first pix_en -> x=0, y=0, active=1, line_start=1 and frame_start=1 for one clk.
- pix_en=1 every 2nd clk, run one line -> active=1 for h 0..639; hsync low exactly at h 656..751 (96 enables); line_start at h_cnt 0 wrap after 800 enables; y goes 0->1.
- Full frame -> vsync low for v 490..491, 2 lines = 1600 enables; next frame_start exactly 420000 enables after the first; x, y = 0 throughout blanking.
- At last pixel (799,524) apply pix_en -> wraps to (0,0), frame_start=1, line_start=1, active=1.
- Hold pix_en=0 for 50 clks mid-line at (300,100) -> x=300 and y=100 stable; strobes 0; hsync, vsync and active unchanged.
- Assert rst_n=0 asynchronously mid-line at (400,200), between clk edges -> outputs go to reset values without waiting for clk. After release, first pix_en gives (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-enable input and raster timing/coordinate bus of the VGA timing generator
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] x;
    logic [8:0] y;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_en,
        output x, y, hsync, vsync, active, line_start, frame_start
    );

    modport slave (
        input pix_en, x, y, hsync, vsync, active, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters and registered sync/active/coordinate/strobe outputs for VGA timing
module vga_timing #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned H_FP            = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BP            = 48,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_FP            = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BP            = 33,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master bus
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       POL    = SYNC_ACTIVE_LOW != 0;

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic       h_wrap, v_wrap, act_nxt, hs_nxt, vs_nxt;

    // Next raster position and its decode; outputs are registered from these so they never lag the counters
    always_comb begin
        h_wrap  = h_cnt == H_LAST;
        v_wrap  = v_cnt == V_LAST;
        h_nxt   = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt   = h_wrap ? (v_wrap ? 10'd0 : v_cnt + 10'd1) : v_cnt;
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ^ POL;
        vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ^ POL;
    end

    // Counters park on the last position in reset so the first enable lands on pixel (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt           <= H_LAST;
            v_cnt           <= V_LAST;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.active      <= 1'b0;
            bus.hsync       <= POL;
            bus.vsync       <= POL;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (bus.pix_en) begin
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            bus.x           <= act_nxt ? h_nxt : 10'd0;
            bus.y           <= act_nxt ? v_nxt[8:0] : 9'd0;
            bus.active      <= act_nxt;
            bus.hsync       <= hs_nxt;
            bus.vsync       <= vs_nxt;
            bus.line_start  <= h_wrap;
            bus.frame_start <= h_wrap && v_wrap;
        end else begin
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of the VGA timing generator at full size and on a shrunken raster
module tb_vga_timing;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_if bus ();
    vga_timing_if sbus ();

    vga_timing dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    // 15 x 12 raster: hsync h 10..12, vsync v 8..9, frame = 180 enables
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus.master));

    task automatic pulse();
        @(negedge clk) bus.pix_en = 1'b1;
        @(negedge clk) bus.pix_en = 1'b0;
    endtask

    task automatic spulse();
        @(negedge clk) sbus.pix_en = 1'b1;
        @(negedge clk) sbus.pix_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.pix_en = 1'b0;
        sbus.pix_en = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({bus.x, bus.y, bus.active, bus.hsync, bus.vsync, bus.line_start, bus.frame_start} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, required 0 0 0 1 1 0 0",
                     bus.x, bus.y, bus.active, bus.hsync, bus.vsync, bus.line_start, bus.frame_start);
        end
        rst_n = 1'b1;
        pulse();
        tests++;
        if ({bus.x, bus.y, bus.active, bus.line_start, bus.frame_start} !== {10'd0, 9'd0, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL first_enable: x=%0d y=%0d act=%b ls=%b fs=%b, required 0 0 1 1 1",
                     bus.x, bus.y, bus.active, bus.line_start, bus.frame_start);
        end
        @(negedge clk);
        tests++;
        if ({bus.line_start, bus.frame_start} !== 2'b00) begin
            fails++;
            $display("FAIL strobe_width: ls=%b fs=%b, required 0 0", bus.line_start, bus.frame_start);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int act_hi = 0;
        for (int k = 1; k <= 800; k++) begin
            int h;
            logic ea, eh;
            pulse();
            h = k % 800;
            ea = h < 640;
            eh = !(h >= 656 && h < 752);
            hs_low += (bus.hsync === 1'b0) ? 1 : 0;
            act_hi += (bus.active === 1'b1) ? 1 : 0;
            tests++;
            if ({bus.active, bus.hsync, bus.line_start, bus.frame_start} !== {ea, eh, h == 0, 1'b0}) begin
                fails++;
                $display("FAIL line_decode h=%0d: act=%b hs=%b ls=%b fs=%b, required %b %b %b 0",
                         h, bus.active, bus.hsync, bus.line_start, bus.frame_start, ea, eh, h == 0);
            end
            tests++;
            if (bus.x !== (ea ? 10'(h) : 10'd0)) begin
                fails++;
                $display("FAIL line_x h=%0d: x=%0d, required %0d", h, bus.x, ea ? h : 0);
            end
        end
        tests++;
        if (bus.y !== 9'd1 || hs_low != 96 || act_hi != 640) begin
            fails++;
            $display("FAIL line_totals: y=%0d hs_low=%0d act=%0d, required 1 96 640", bus.y, hs_low, act_hi);
        end
    endtask

    task automatic test_hold();
        logic hs, vs, act;
        repeat (300) pulse();
        tests++;
        if (bus.x !== 10'd300 || bus.y !== 9'd1) begin
            fails++;
            $display("FAIL hold_pos: x=%0d y=%0d, required 300 1", bus.x, bus.y);
        end
        hs = bus.hsync;
        vs = bus.vsync;
        act = bus.active;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.x, bus.y, bus.hsync, bus.vsync, bus.active, bus.line_start, bus.frame_start} !== {10'd300, 9'd1, hs, vs, act, 2'b00}) begin
                fails++;
                $display("FAIL hold_stable clk=%0d: x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                         k, bus.x, bus.y, bus.hsync, bus.vsync, bus.active, bus.line_start, bus.frame_start);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (100) pulse();
        tests++;
        if (bus.x !== 10'd400 || bus.active !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_pos: x=%0d act=%b, required 400 1", bus.x, bus.active);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.x, bus.y, bus.active, bus.hsync, bus.vsync, bus.line_start, bus.frame_start} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, required 0 0 0 1 1 0 0",
                     bus.x, bus.y, bus.active, bus.hsync, bus.vsync, bus.line_start, bus.frame_start);
        end
        @(negedge clk) rst_n = 1'b1;
        pulse();
        tests++;
        if ({bus.x, bus.y, bus.active, bus.line_start, bus.frame_start} !== {10'd0, 9'd0, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL restart_frame: x=%0d y=%0d act=%b ls=%b fs=%b, required 0 0 1 1 1",
                     bus.x, bus.y, bus.active, bus.line_start, bus.frame_start);
        end
    endtask

    task automatic test_frame();
        int vs_low = 0;
        int fs_cnt = 0;
        spulse();
        tests++;
        if ({sbus.x, sbus.y, sbus.active, sbus.frame_start} !== {10'd0, 9'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL small_first: x=%0d y=%0d act=%b fs=%b, required 0 0 1 1",
                     sbus.x, sbus.y, sbus.active, sbus.frame_start);
        end
        for (int k = 1; k <= 180; k++) begin
            int h, v;
            logic ea, eh, ev;
            spulse();
            h = k % 15;
            v = (k / 15) % 12;
            ea = h < 8 && v < 6;
            eh = !(h >= 10 && h < 13);
            ev = !(v >= 8 && v < 10);
            vs_low += (sbus.vsync === 1'b0) ? 1 : 0;
            fs_cnt += (sbus.frame_start === 1'b1) ? 1 : 0;
            tests++;
            if ({sbus.active, sbus.hsync, sbus.vsync, sbus.line_start, sbus.frame_start} !== {ea, eh, ev, h == 0, k == 180}) begin
                fails++;
                $display("FAIL frame_decode h=%0d v=%0d: act=%b hs=%b vs=%b ls=%b fs=%b, required %b %b %b %b %b",
                         h, v, sbus.active, sbus.hsync, sbus.vsync, sbus.line_start, sbus.frame_start,
                         ea, eh, ev, h == 0, k == 180);
            end
            tests++;
            if (sbus.x !== (ea ? 10'(h) : 10'd0) || sbus.y !== (ea ? 9'(v) : 9'd0)) begin
                fails++;
                $display("FAIL frame_xy h=%0d v=%0d: x=%0d y=%0d", h, v, sbus.x, sbus.y);
            end
        end
        tests++;
        if (vs_low != 30 || fs_cnt != 1) begin
            fails++;
            $display("FAIL frame_totals: vs_low=%0d fs=%0d, required 30 1", vs_low, fs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) sbus.pix_en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            tests++;
            if (sbus.line_start !== (k % 15 == 0)) begin
                fails++;
                $display("FAIL b2b_line_start k=%0d: ls=%b, required %b", k, sbus.line_start, k % 15 == 0);
            end
        end
        sbus.pix_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_hold();
        test_async_reset();
        test_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
